// File: rtl/rv32_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : rv32_div_unit
// Brief   : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//           Optional macro DIV_EARLY_OUT_EN retires |dividend| < |divisor| in 1 cycle.
// Revision: 1.0 - initial release
// ============================================================================
module rv32_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int             CW     = $clog2(XLEN);
    localparam logic [CW-1:0]  c_last = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dvsr;
    logic [XLEN-1:0]   r_result;
    logic              r_is_rem;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_early;
    logic              w_special;
    logic              w_accept;
    logic [XLEN-1:0]   w_special_result;
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;

    // Magnitude of the most negative value stays 0x8000_0000 as an unsigned number
    assign w_signed   = ~op[0];
    assign w_a_neg    = w_signed & dividend[XLEN-1];
    assign w_b_neg    = w_signed & divisor[XLEN-1];
    assign w_a_mag    = w_a_neg ? -dividend : dividend;
    assign w_b_mag    = w_b_neg ? -divisor  : divisor;
    assign w_div_zero = (divisor == '0);
    assign w_ovf      = w_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
    assign w_early    = !w_div_zero && (w_a_mag < w_b_mag);
`else
    assign w_early    = 1'b0;
`endif
    assign w_special  = w_div_zero | w_ovf | w_early;
    assign w_accept   = (r_state == S_IDLE) && in_valid && !flush;

    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = op[1] ? dividend : '1;
        end else if (w_ovf) begin
            w_special_result = op[1] ? '0 : dividend;
        end else if (w_early) begin
            w_special_result = op[1] ? dividend : '0;
        end
    end

    // One restoring step: partial remainder is XLEN+1 bits wide before the compare
    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_rem_next = w_ge ? (w_rem_sh[XLEN-1:0] - r_dvsr) : w_rem_sh[XLEN-1:0];

    assign w_q_fix    = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix    = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = (r_state == S_IDLE);
        out_valid    = (r_state == S_DONE);
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_state_next = w_special ? S_DONE : S_CALC;
                S_CALC:  if (r_cnt == c_last) w_state_next = S_FIXUP;
                S_FIXUP: w_state_next = S_DONE;
                S_DONE:  if (out_ready) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_result <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_dvsr   <= w_b_mag;
            r_is_rem <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_special) begin
                r_result <= w_special_result;
            end
        end else if ((r_state == S_CALC) && !flush) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
        end else if ((r_state == S_FIXUP) && !flush) begin
            r_result <= r_is_rem ? w_r_fix : w_q_fix;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_rv32_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32_div_unit
// Brief   : Directed self-checking bench for rv32_div_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv32_div_unit;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Issue one op with out_ready=1; returns result and edges from acceptance to out_valid
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; dividend = a; divisor = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_op_timeout op=%0d a=%h b=%h got out_valid=%b want 1", o, a, b, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [31:0] r;
        int lat;
        run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", r, 32'd14); end
        checks++; if (lat != 34) begin errors++; $display("FAIL divu_latency got %0d want 34", lat); end
        run_op(OP_REMU, 32'd100, 32'd7, r, lat);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want %h", r, 32'd2); end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, r, lat);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max_1 got %h want ffffffff", r); end
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL divu_8000_ffff got %h want 0", r); end
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'h10, r, lat);
        checks++; if (r !== 32'hF) begin errors++; $display("FAIL remu_max_16 got %h want f", r); end
    endtask

    task automatic test_signed();
        logic [31:0] r;
        int lat;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, lat);
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h want fffffffd", r); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h want ffffffff", r); end
        run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, r, lat);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL rem_7_m2 got %h want 1", r); end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, r, lat);
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2 got %h want fffffffd", r); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, r, lat);
        checks++; if (r !== 32'd3) begin errors++; $display("FAIL div_m7_m2 got %h want 3", r); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, r, lat);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_m2 got %h want ffffffff", r); end
        run_op(OP_DIV, 32'h8000_0000, 32'd2, r, lat);
        checks++; if (r !== 32'hC000_0000) begin errors++; $display("FAIL div_min_2 got %h want c0000000", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        int lat;
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h want 80000000", r); end
        checks++; if (lat != 1) begin errors++; $display("FAIL div_ovf_latency got %0d want 1", lat); end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rem_ovf got %h want 0", r); end
    endtask

    task automatic test_div_zero();
        logic [31:0] r;
        int lat;
        run_op(OP_DIVU, 32'd5, 32'd0, r, lat);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_5_0 got %h want ffffffff", r); end
        checks++; if (lat != 1) begin errors++; $display("FAIL divu_5_0_latency got %0d want 1", lat); end
        run_op(OP_REM, 32'd5, 32'd0, r, lat);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL rem_5_0 got %h want 5", r); end
        checks++; if (lat != 1) begin errors++; $display("FAIL rem_5_0_latency got %0d want 1", lat); end
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, r, lat);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m5_0 got %h want ffffffff", r); end
        run_op(OP_REMU, 32'hFFFF_FFFB, 32'd0, r, lat);
        checks++; if (r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL remu_big_0 got %h want fffffffb", r); end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        @(negedge clk);
        op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        dividend = 32'd50; divisor = 32'd5;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got out_valid=%b want 1", out_valid); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d want 0 (result=%h out_valid=%b)", bad, result, out_valid); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_no_restart got %0d valid cycles want 0", bad); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int lat;
        int seen;
        @(negedge clk);
        op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
        run_op(OP_DIVU, 32'd9, 32'd3, r, lat);
        checks++; if (r !== 32'd3) begin errors++; $display("FAIL after_flush_9_3 got %h want 3", r); end
        // Flush must win over an accept presented in the same cycle
        @(negedge clk);
        op = OP_DIVU; dividend = 32'd5; divisor = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_beats_accept got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        int lat;
        int seen;
        run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
        @(negedge clk);
        op = OP_DIVU; dividend = 32'd200; divisor = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_handshake got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result got %h want 0", result); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_result got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_early_out();
        logic [31:0] r;
        int lat;
        int exp_lat;
`ifdef DIV_EARLY_OUT_EN
        exp_lat = 1;
`else
        exp_lat = 34;
`endif
        run_op(OP_DIVU, 32'd3, 32'd9, r, lat);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL divu_3_9 got %h want 0", r); end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL divu_3_9_latency got %0d want %0d", lat, exp_lat); end
        run_op(OP_REM, 32'hFFFF_FFFD, 32'd9, r, lat);
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL rem_m3_9 got %h want fffffffd", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int lat;
        run_op(OP_DIVU, 32'd1000, 32'd10, r, lat);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_handoff_ready got %b want 1", in_ready); end
        checks++; if (r !== 32'd100) begin errors++; $display("FAIL b2b_first got %h want 64", r); end
        run_op(OP_REMU, 32'd1000, 32'd7, r, lat);
        checks++; if (r !== 32'd6) begin errors++; $display("FAIL b2b_second got %h want 6", r); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        test_early_out();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
